// File: rtl/change_pkg.sv
// change_pkg: shared types and constants for the change dispenser.
//   - state_t       : dispenser FSM state encoding
//   - HOP_Q/D/N     : hopper indices (quarter, dime, nickel)
//   - DEN_Q/D/N     : coin values in cents
//   - hop_cents()   : hopper index -> coin value in cents
//   - hop_onehot()  : hopper index -> coin_eject / coin_sensed bit mask
package change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [1:0] HOP_Q = 2'd0;
  localparam logic [1:0] HOP_D = 2'd1;
  localparam logic [1:0] HOP_N = 2'd2;

  localparam logic [7:0] DEN_Q = 8'd25;
  localparam logic [7:0] DEN_D = 8'd10;
  localparam logic [7:0] DEN_N = 8'd5;

  function automatic logic [7:0] hop_cents(input logic [1:0] hop);
    case (hop)
      HOP_Q:   return DEN_Q;
      HOP_D:   return DEN_D;
      HOP_N:   return DEN_N;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] hop_onehot(input logic [1:0] hop);
    case (hop)
      HOP_Q:   return 3'b001;
      HOP_D:   return 3'b010;
      HOP_N:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_hopper_timer.sv
// hopper_timer: shared eject-pulse / sense-timeout counter for the hoppers.
// A start pulse begins an eject phase of EJECT_CYC cycles; pulse_end is high
// in the last cycle of that phase. A timeout phase of TIMEOUT_CYC cycles
// follows; expire is high in its last cycle, after which the timer idles.
// stop returns the timer to idle (used when the coin is sensed).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a new eject phase (wins over stop)
//   stop        abandon the current attempt
//   pulse_end   last cycle of the eject phase
//   expire      last cycle of the timeout phase
module hopper_timer #(
  parameter int EJECT_CYC   = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic pulse_end,
  output logic expire
);

  localparam int MAX_CYC = (EJECT_CYC > TIMEOUT_CYC) ? EJECT_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] EJ_LAST = CW'(EJECT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {PH_IDLE, PH_PULSE, PH_TMO} phase_t;

  phase_t          phase;
  logic [CW-1:0]   cnt;

  assign pulse_end = (phase == PH_PULSE) && (cnt == EJ_LAST);
  assign expire    = (phase == PH_TMO)   && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else if (start) begin
      phase <= PH_PULSE;
      cnt   <= '0;
    end else if (stop) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else begin
      case (phase)
        PH_PULSE: begin
          if (cnt == EJ_LAST) begin
            phase <= PH_TMO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_TMO: begin
          if (cnt == TO_LAST) begin
            phase <= PH_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          phase <= PH_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount back out through three coin hoppers
// (quarter, dime, nickel), choosing coins greedily, tracking inventory,
// retrying hoppers that do not sense, and reporting any shortfall.
// Optional feature macro: CHANGE_STATS_EN adds coins_paid / timeouts counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   change_req, change_amount     request strobe and amount (cents), idle only
//   ready                         high while idle
//   inv_load, inv_sel, inv_value  inventory write (idle only; sel 3 ignored)
//   coin_eject[2:0]               one-hot eject drive {nickel, dime, quarter}
//   coin_sensed[2:0]              one-cycle sensor pulses, same bit order
//   remaining                     cents still owed
//   done, short, shortfall        completion pulse, shortfall flag and amount
//   sensor_err                    sticky unexpected-sense flag
//   inv_q, inv_d, inv_n           hopper inventories
//   coins_paid, timeouts          (CHANGE_STATS_EN only) statistics
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int INV_W       = 8,
  parameter int EJECT_CYC   = 4,
  parameter int TIMEOUT_CYC = 200,
  parameter int MAX_RETRY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amount,
  output logic             ready,
  input  logic             inv_load,
  input  logic [1:0]       inv_sel,
  input  logic [INV_W-1:0] inv_value,
  output logic [2:0]       coin_eject,
  input  logic [2:0]       coin_sensed,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] shortfall,
  output logic             sensor_err,
`ifdef CHANGE_STATS_EN
  output logic [15:0]      coins_paid,
  output logic [7:0]       timeouts,
`endif
  output logic [INV_W-1:0] inv_q,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_n
);

  localparam int RW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  state_t          state;
  logic [1:0]      sel_idx;
  logic [RW-1:0]   retry;

  logic            sel_found;
  logic [1:0]      sel_next;
  logic [2:0]      active_mask;
  logic            sense_hit;
  logic            spurious;
  logic            retry_ok;
  logic            tmr_start;
  logic            tmr_stop;
  logic            pulse_end;
  logic            expire;
  logic [AMT_W-1:0] sel_cents;

  // Greedy pick: largest coin that fits in what is owed and is in stock.
  always_comb begin
    sel_found = 1'b0;
    sel_next  = HOP_Q;
    if (remaining >= AMT_W'(DEN_Q) && inv_q != '0) begin
      sel_found = 1'b1;
      sel_next  = HOP_Q;
    end else if (remaining >= AMT_W'(DEN_D) && inv_d != '0) begin
      sel_found = 1'b1;
      sel_next  = HOP_D;
    end else if (remaining >= AMT_W'(DEN_N) && inv_n != '0) begin
      sel_found = 1'b1;
      sel_next  = HOP_N;
    end
  end

  // A sense is only expected from the hopper currently being driven.
  always_comb begin
    active_mask = 3'b000;
    if (state == ST_EJECT || state == ST_WAIT)
      active_mask = hop_onehot(sel_idx);
    sense_hit = |(coin_sensed & active_mask);
    spurious  = |(coin_sensed & ~active_mask);
    retry_ok  = (retry < MAX_R);
    sel_cents = AMT_W'(hop_cents(sel_idx));
    tmr_start = ((state == ST_SELECT) && sel_found) ||
                ((state == ST_WAIT) && !sense_hit && expire && retry_ok);
    tmr_stop  = sense_hit;
  end

  hopper_timer #(
    .EJECT_CYC   (EJECT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (tmr_start),
    .stop      (tmr_stop),
    .pulse_end (pulse_end),
    .expire    (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      sel_idx    <= HOP_Q;
      retry      <= '0;
      coin_eject <= 3'b000;
      remaining  <= '0;
      done       <= 1'b0;
      short      <= 1'b0;
      shortfall  <= '0;
      sensor_err <= 1'b0;
      inv_q      <= '0;
      inv_d      <= '0;
      inv_n      <= '0;
    end else begin
      done <= 1'b0;
      if (spurious)
        sensor_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (inv_load) begin
            case (inv_sel)
              HOP_Q:   inv_q <= inv_value;
              HOP_D:   inv_d <= inv_value;
              HOP_N:   inv_n <= inv_value;
              default: ;
            endcase
          end
          if (change_req) begin
            remaining <= change_amount;
            shortfall <= '0;
            short     <= 1'b0;
            ready     <= 1'b0;
            state     <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (sel_found) begin
            sel_idx    <= sel_next;
            retry      <= '0;
            coin_eject <= hop_onehot(sel_next);
            state      <= ST_EJECT;
          end else begin
            // done/short/shortfall are registered here so they are valid
            // during the single FINISH cycle.
            done      <= 1'b1;
            shortfall <= remaining;
            short     <= (remaining != '0);
            state     <= ST_FINISH;
          end
        end

        ST_EJECT, ST_WAIT: begin
          if (sense_hit) begin
            remaining  <= remaining - sel_cents;
            coin_eject <= 3'b000;
            state      <= ST_SELECT;
            case (sel_idx)
              HOP_Q:   inv_q <= inv_q - 1'b1;
              HOP_D:   inv_d <= inv_d - 1'b1;
              HOP_N:   inv_n <= inv_n - 1'b1;
              default: ;
            endcase
          end else if (state == ST_EJECT) begin
            if (pulse_end) begin
              coin_eject <= 3'b000;
              state      <= ST_WAIT;
            end
          end else if (expire) begin
            if (retry_ok) begin
              retry      <= retry + 1'b1;
              coin_eject <= hop_onehot(sel_idx);
              state      <= ST_EJECT;
            end else begin
              // Out of retries: treat the hopper as empty so SELECT skips it.
              state <= ST_SELECT;
              case (sel_idx)
                HOP_Q:   inv_q <= '0;
                HOP_D:   inv_d <= '0;
                HOP_N:   inv_n <= '0;
                default: ;
              endcase
            end
          end
        end

        ST_FINISH: begin
          remaining <= '0;
          ready     <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          coin_eject <= 3'b000;
          ready      <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CHANGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      coins_paid <= '0;
      timeouts   <= '0;
    end else begin
      if (sense_hit)
        coins_paid <= coins_paid + 16'd1;
      if (state == ST_WAIT && !sense_hit && expire && timeouts != 8'hFF)
        timeouts <= timeouts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       change_req;
  logic [7:0] change_amount;
  logic       ready;
  logic       inv_load;
  logic [1:0] inv_sel;
  logic [7:0] inv_value;
  logic [2:0] coin_eject;
  logic [2:0] coin_sensed;
  logic [7:0] remaining;
  logic       done;
  logic       short;
  logic [7:0] shortfall;
  logic       sensor_err;
  logic [7:0] inv_q, inv_d, inv_n;
`ifdef CHANGE_STATS_EN
  logic [15:0] coins_paid;
  logic [7:0]  timeouts;
`endif

  logic [2:0] echo_s = 3'b000;
  logic [2:0] inj_s  = 3'b000;
  logic [2:0] echo_mask = 3'b111;
  int         echo_at = 4;
  assign coin_sensed = echo_s | inj_s;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [2:0]  prev_ej = 3'b000;
  logic [2:0]  ej_bit  = 3'b000;
  int          age = 0;
  int          done_cnt = 0;
  logic [63:0] ej_code  = '0;
  logic [63:0] rem_code = '0;

  change_dispenser dut (
    .clk           (clk),
    .rst           (rst),
    .change_req    (change_req),
    .change_amount (change_amount),
    .ready         (ready),
    .inv_load      (inv_load),
    .inv_sel       (inv_sel),
    .inv_value     (inv_value),
    .coin_eject    (coin_eject),
    .coin_sensed   (coin_sensed),
    .remaining     (remaining),
    .done          (done),
    .short         (short),
    .shortfall     (shortfall),
    .sensor_err    (sensor_err),
`ifdef CHANGE_STATS_EN
    .coins_paid    (coins_paid),
    .timeouts      (timeouts),
`endif
    .inv_q         (inv_q),
    .inv_d         (inv_d),
    .inv_n         (inv_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hopper model: echoes an eject echo_at cycles after its rising edge (if the
  // hopper is enabled in echo_mask) and logs each eject attempt and the amount
  // owed at that moment, packed one nibble / one byte per attempt.
  always @(posedge clk) begin
    #1;
    echo_s = 3'b000;
    if (coin_eject != 3'b000 && prev_ej == 3'b000) begin
      ej_bit   = coin_eject;
      age      = 1;
      ej_code  = (ej_code << 4) | ((coin_eject == 3'b001) ? 64'd1 :
                                   (coin_eject == 3'b010) ? 64'd2 : 64'd3);
      rem_code = (rem_code << 8) | {56'd0, remaining};
    end else if (age != 0) begin
      age++;
    end
    if (age == echo_at && (ej_bit & echo_mask) != 3'b000) begin
      echo_s = ej_bit;
      age    = 0;
    end
    if (done) done_cnt++;
    prev_ej = coin_eject;
  end

  task automatic load(input logic [1:0] sel, input logic [7:0] val);
    inv_load  = 1'b1;
    inv_sel   = sel;
    inv_value = val;
    @(posedge clk); #1;
    inv_load  = 1'b0;
  endtask

  task automatic request(input logic [7:0] amt);
    ej_code  = '0;
    rem_code = '0;
    change_req    = 1'b1;
    change_amount = amt;
    @(posedge clk); #1;
    change_req    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, got}, 64'd1);
  endtask

  task automatic wait_eject(input string tag, input logic [2:0] mask, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (coin_eject == mask) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(tag, {63'd0, got}, 64'd1);
  endtask

  int dc0;

  initial begin
    rst = 1'b1; change_req = 1'b0; change_amount = '0;
    inv_load = 1'b0; inv_sel = '0; inv_value = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ready",      {63'd0, ready},      64'd1);
    check("rst_eject",      {61'd0, coin_eject}, 64'd0);
    check("rst_remaining",  {56'd0, remaining},  64'd0);
    check("rst_done",       {63'd0, done},       64'd0);
    check("rst_short",      {63'd0, short},      64'd0);
    check("rst_shortfall",  {56'd0, shortfall},  64'd0);
    check("rst_sensor_err", {63'd0, sensor_err}, 64'd0);
    check("rst_inv", {40'd0, inv_q, inv_d, inv_n}, 64'd0);

    // inv_sel 3 writes nothing
    load(2'd3, 8'd7);
    check("sel3_ignored", {40'd0, inv_q, inv_d, inv_n}, 64'd0);

    // T1: 10/10/10, request 40 -> Q, D, N
    load(2'd0, 8'd10); load(2'd1, 8'd10); load(2'd2, 8'd10);
    request(8'd40);
    wait_done("t1_done", 200);
    check("t1_short",     {63'd0, short},     64'd0);
    check("t1_shortfall", {56'd0, shortfall}, 64'd0);
    check("t1_order",     ej_code,            64'h123);
    check("t1_inv", {40'd0, inv_q, inv_d, inv_n}, 64'h090909);
    @(posedge clk); #1;
    check("t1_ready_after", {63'd0, ready}, 64'd1);

    // T2: Q=0, D=5, N=0, request 30 -> three dimes
    load(2'd0, 8'd0); load(2'd1, 8'd5); load(2'd2, 8'd0);
    request(8'd30);
    wait_done("t2_done", 200);
    check("t2_order",     ej_code,            64'h222);
    check("t2_rem_trace", rem_code,           64'h1E140A);
    check("t2_remaining", {56'd0, remaining}, 64'd0);
    check("t2_inv_d",     {56'd0, inv_d},     64'd2);
    check("t2_short",     {63'd0, short},     64'd0);
    @(posedge clk); #1;

    // T3: quarter hopper silent, D=2, N=1, request 25
    echo_mask = 3'b110;
    load(2'd0, 8'd5); load(2'd1, 8'd2); load(2'd2, 8'd1);
    request(8'd25);
    wait_done("t3_done", 1500);
    check("t3_order",     ej_code,  64'h111223);
    check("t3_rem_trace", rem_code, 64'h19191919_0F05 | 64'h0);
    check("t3_inv", {40'd0, inv_q, inv_d, inv_n}, 64'h000000);
    check("t3_short",     {63'd0, short},     64'd0);
    check("t3_sensor_err",{63'd0, sensor_err},64'd0);
    echo_mask = 3'b111;
    @(posedge clk); #1;

    // T4: D=1 only, request 17 -> one dime, shortfall 7
    load(2'd1, 8'd1);
    request(8'd17);
    wait_done("t4_done", 200);
    check("t4_order",     ej_code,            64'h2);
    check("t4_short",     {63'd0, short},     64'd1);
    check("t4_shortfall", {56'd0, shortfall}, 64'd7);
    repeat (4) @(posedge clk); #1;
    check("t4_shortfall_hold", {56'd0, shortfall}, 64'd7);
    check("t4_remaining",      {56'd0, remaining}, 64'd0);

    // T5: busy request, busy inv_load, stray nickel sense in a dime WAIT
    echo_at = 8;
    load(2'd1, 8'd3); load(2'd2, 8'd4);
    dc0 = done_cnt;
    request(8'd20);
    check("t5_ready_busy", {63'd0, ready}, 64'd0);
    wait_eject("t5_dime_eject", 3'b010, 20);
    repeat (4) @(posedge clk); #1;
    inj_s = 3'b100;
    change_req = 1'b1; change_amount = 8'd5;
    inv_load = 1'b1; inv_sel = 2'd2; inv_value = 8'd9;
    @(posedge clk); #1;
    inj_s = 3'b000; change_req = 1'b0; inv_load = 1'b0;
    check("t5_sensor_err", {63'd0, sensor_err}, 64'd1);
    check("t5_inv_n_mid",  {56'd0, inv_n},      64'd4);
    check("t5_rem_mid",    {56'd0, remaining},  64'd20);
    wait_done("t5_done", 300);
    check("t5_short",  {63'd0, short}, 64'd0);
    check("t5_order",  ej_code,        64'h22);
    check("t5_inv", {40'd0, inv_q, inv_d, inv_n}, 64'h000104);
    repeat (5) @(posedge clk); #1;
    check("t5_one_done",   done_cnt - dc0,      64'd1);
    check("t5_ready_idle", {63'd0, ready},      64'd1);
    check("t5_err_sticky", {63'd0, sensor_err}, 64'd1);
    echo_at = 4;

    // T6: amount 0 -> done two cycles after the request
    request(8'd0);
    check("t6_done_early", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    check("t6_done",      {63'd0, done},      64'd1);
    check("t6_short",     {63'd0, short},     64'd0);
    check("t6_shortfall", {56'd0, shortfall}, 64'd0);
    @(posedge clk); #1;

    // T7: reset in the middle of a quarter eject
    echo_mask = 3'b000;
    load(2'd0, 8'd3);
    request(8'd25);
    wait_eject("t7_q_eject", 3'b001, 20);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t7_eject",     {61'd0, coin_eject}, 64'd0);
    check("t7_ready",     {63'd0, ready},      64'd1);
    check("t7_inv", {40'd0, inv_q, inv_d, inv_n}, 64'd0);
    check("t7_remaining", {56'd0, remaining},  64'd0);
    check("t7_sensor_err",{63'd0, sensor_err}, 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t7_idle_eject", {61'd0, coin_eject}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
